mux_2_1_rr_arb: RTL

Two-input round-robin stream arbiter that feeds the 2:1 mux stage. It accepts single-beat transfers from two valid/ready sources (a, b), picks one per cycle with fair alternation on contention, and holds the winner in a one-entry output register. It also exports `sel`, the source index of the held beat, so a downstream `mux_2_1` variant or debug logic sees the same selection the arbiter made.

---
 rtl/mux_2_1_rr_arb.sv | 60 ++++++
 1 files changed

// File: rtl/mux_2_1_rr_arb.sv
// Two-input round-robin stream arbiter with a one-entry output register.
// sel reports which source the held beat came from, updated with the data.
module mux_2_1_rr_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             sel
);

    logic out_free;
    logic grant_a;
    logic grant_b;
    logic last;

    // On contention the source not served last wins; last=1 means b was served last.
    always_comb begin
        out_free = !y_valid || y_ready;
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        if (out_free && !rst) begin
            grant_a = a_valid && (!b_valid || last);
            grant_b = b_valid && (!a_valid || !last);
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_data  <= '0;
            y_valid <= 1'b0;
            sel     <= 1'b0;
            last    <= 1'b1;
        end else if (grant_a) begin
            y_data  <= a_data;
            y_valid <= 1'b1;
            sel     <= 1'b0;
            last    <= 1'b0;
        end else if (grant_b) begin
            y_data  <= b_data;
            y_valid <= 1'b1;
            sel     <= 1'b1;
            last    <= 1'b1;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule
